pc_bank_access_engine: RTL and testbench

PC_BANK_ACCESS_ENGINE -- requirements
Module: pc_bank_access_engine

---
 rtl/pc_if_pkg.sv | 38 +++
 rtl/pc_if_timeout.sv | 34 +++
 rtl/pc_bank_access_engine.sv | 237 +++++++++++++++++++++++
 tb/tb_pc_bank_access_engine.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_if_pkg
//  Purpose  : Shared definitions for the PC bank access engine: one-hot state
//             encoding, command byte field positions and the bytes-per-bank
//             helper.
//  Revision : 1.0 - initial release
// ============================================================================
package pc_if_pkg;

  // One-hot state encoding of the frame engine.
  typedef enum logic [10:0] {
    ST_IDLE    = 11'b000_0000_0001,
    ST_CMD     = 11'b000_0000_0010,
    ST_LEN     = 11'b000_0000_0100,
    ST_CHECK   = 11'b000_0000_1000,
    ST_LOAD    = 11'b000_0001_0000,
    ST_WAIT_RX = 11'b000_0010_0000,
    ST_RX      = 11'b000_0100_0000,
    ST_WRITE   = 11'b000_1000_0000,
    ST_WAIT_TX = 11'b001_0000_0000,
    ST_TX      = 11'b010_0000_0000,
    ST_NEXT    = 11'b100_0000_0000
  } pc_state_e;

  // Command byte layout.
  localparam int c_CMD_WR_BIT    = 7;
  localparam int c_CMD_AI_BIT    = 6;
  localparam int c_CMD_ADDR_HI   = 3;
  localparam int c_CMD_ADDR_LO   = 0;

  // Number of serial bytes needed to carry one bank, rounded up.
  function automatic int pc_nb(input int width);
    return (width + 7) / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_if_timeout.sv
`default_nettype none
// ============================================================================
//  Module   : pc_if_timeout
//  Purpose  : Inter-byte timeout counter. Clear has priority, increments stop
//             at all-ones and the saturated state is flagged.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_if_timeout #(
  parameter int WIDTH = 16
) (
  input  logic i_clk,
  input  logic i_arst_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_sat
);

  logic [WIDTH-1:0] r_cnt;

  assign o_sat = &r_cnt;

  // Count idle receive cycles; restart on every accepted byte.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && !o_sat) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_bank_access_engine.sv
`default_nettype none
// ============================================================================
//  Module   : pc_bank_access_engine
//  Purpose  : Byte-serial command engine giving a PC (via a UART byte link)
//             read and write access to a set of register banks.
//             Frame: CMD, LEN, payload (MSB-first bytes per bank).
//             Optional: define PC_BANK_ACCESS_CHKSUM_EN to append/expect an
//             XOR checksum byte after every bank payload.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_bank_access_engine
  import pc_if_pkg::*;
#(
  parameter int NUM_BANKS     = 8,
  parameter int BANK_WIDTH    = 56,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                         i_clk,
  input  logic                         i_arst_n,
  input  logic                         i_pc_valid,
  input  logic [7:0]                   i_pc_data,
  output logic                         o_pc_rd,
  input  logic                         i_pc_rdy,
  output logic [7:0]                   o_pc_data,
  output logic                         o_pc_wr,
  output logic [$clog2(NUM_BANKS)-1:0] o_bank_addr,
  input  logic [BANK_WIDTH-1:0]        i_bank_rdata,
  output logic [BANK_WIDTH-1:0]        o_bank_wdata,
  output logic                         o_bank_wr,
  output logic                         o_busy,
  output logic                         o_err
);

  localparam int c_AW = $clog2(NUM_BANKS);
  localparam int c_NB = pc_nb(BANK_WIDTH);
  localparam int c_SW = c_NB * 8;

`ifdef PC_BANK_ACCESS_CHKSUM_EN
  localparam bit c_CHKSUM = 1'b1;
`else
  localparam bit c_CHKSUM = 1'b0;
`endif

  // Byte index of the last data byte, of the checksum slot, and of the last
  // byte of a bank on the wire (checksum included when enabled).
  localparam logic [3:0] c_DLAST = 4'(c_NB - 1);
  localparam logic [3:0] c_NBW   = 4'(c_NB);
  localparam logic [3:0] c_LAST  = 4'(c_NB - 1 + (c_CHKSUM ? 1 : 0));

  pc_state_e         r_state;
  logic              r_cmd_wr;
  logic              r_cmd_ai;
  logic [3:0]        r_start;
  logic [7:0]        r_len;
  logic [c_AW-1:0]   r_addr;
  logic [3:0]        r_byte_cnt;
  logic [7:0]        r_chk;
  logic [c_SW-1:0]   r_shift;
  logic [7:0]        r_pc_data;
  logic [BANK_WIDTH-1:0] r_bank_wdata;
  logic              r_bank_wr;
  logic              r_err;

  logic              w_rx_state;
  logic              w_to_inc;
  logic              w_to_sat;
  logic              w_range_err;
  logic [8:0]        w_end;
  logic [c_SW-1:0]   w_rdata_ext;
  logic [c_SW-1:0]   w_shift_nx;
  logic [c_SW-1:0]   w_shift_in;

  assign w_rx_state = (r_state == ST_IDLE) || (r_state == ST_LEN) ||
                      (r_state == ST_WAIT_RX);
  assign o_pc_rd    = i_arst_n & i_pc_valid & w_rx_state;
  assign o_pc_wr    = i_pc_rdy & (r_state == ST_WAIT_TX);
  assign o_busy     = (r_state != ST_IDLE);
  assign o_pc_data  = r_pc_data;
  assign o_bank_addr  = r_addr;
  assign o_bank_wdata = r_bank_wdata;
  assign o_bank_wr  = r_bank_wr;
  assign o_err      = r_err;

  // Timeout only advances while waiting for an expected byte.
  assign w_to_inc = ((r_state == ST_LEN) || (r_state == ST_WAIT_RX)) && !i_pc_valid;

  // Last bank touched; only bounded when auto-increment walks the address.
  assign w_end       = {5'b0, r_start} + {1'b0, r_len};
  assign w_range_err = ({1'b0, r_start} >= 5'(NUM_BANKS)) ||
                       (r_cmd_ai && (w_end >= 9'(NUM_BANKS)));

  assign w_rdata_ext = c_SW'(i_bank_rdata);
  assign w_shift_nx  = r_shift << 8;
  assign w_shift_in  = (r_shift << 8) | c_SW'(i_pc_data);

  pc_if_timeout #(
    .WIDTH (TIMEOUT_WIDTH)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_clear  (o_pc_rd),
    .i_inc    (w_to_inc),
    .o_sat    (w_to_sat)
  );

  // Frame sequencer with registered bank/error strobes and TX byte.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state      <= ST_IDLE;
      r_cmd_wr     <= 1'b0;
      r_cmd_ai     <= 1'b0;
      r_start      <= '0;
      r_len        <= '0;
      r_addr       <= '0;
      r_byte_cnt   <= '0;
      r_chk        <= '0;
      r_shift      <= '0;
      r_pc_data    <= '0;
      r_bank_wdata <= '0;
      r_bank_wr    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_bank_wr <= 1'b0;
      r_err     <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_pc_valid) begin
            r_cmd_wr <= i_pc_data[c_CMD_WR_BIT];
            r_cmd_ai <= i_pc_data[c_CMD_AI_BIT];
            r_start  <= i_pc_data[c_CMD_ADDR_HI:c_CMD_ADDR_LO];
            r_state  <= ST_CMD;
          end
        end
        ST_CMD: begin
          r_byte_cnt <= '0;
          r_chk      <= '0;
          r_state    <= ST_LEN;
        end
        ST_LEN: begin
          if (i_pc_valid) begin
            r_len   <= i_pc_data;
            r_state <= ST_CHECK;
          end else if (w_to_sat) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (w_range_err) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_addr  <= r_start[c_AW-1:0];
            r_state <= r_cmd_wr ? ST_WAIT_RX : ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_shift    <= w_rdata_ext;
          r_pc_data  <= w_rdata_ext[c_SW-1 -: 8];
          r_byte_cnt <= '0;
          r_chk      <= '0;
          r_state    <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (i_pc_rdy) begin
            r_state <= ST_TX;
          end
        end
        ST_TX: begin
          r_chk   <= r_chk ^ r_pc_data;
          r_shift <= w_shift_nx;
          if (r_byte_cnt == c_LAST) begin
            r_state <= ST_NEXT;
          end else begin
            r_byte_cnt <= r_byte_cnt + 4'd1;
            // After the last data byte the running XOR becomes the checksum.
            if (c_CHKSUM && (r_byte_cnt == c_DLAST)) begin
              r_pc_data <= r_chk ^ r_pc_data;
            end else begin
              r_pc_data <= w_shift_nx[c_SW-1 -: 8];
            end
            r_state <= ST_WAIT_TX;
          end
        end
        ST_WAIT_RX: begin
          if (i_pc_valid) begin
            // Checksum byte folds into the XOR so a good bank ends at zero.
            r_chk <= r_chk ^ i_pc_data;
            if (r_byte_cnt != c_NBW) begin
              r_shift <= w_shift_in;
            end
            r_state <= ST_RX;
          end else if (w_to_sat) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_RX: begin
          if (r_byte_cnt == c_LAST) begin
            if (c_CHKSUM && (r_chk != 8'h00)) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_WRITE;
            end
          end else begin
            r_byte_cnt <= r_byte_cnt + 4'd1;
            r_state    <= ST_WAIT_RX;
          end
        end
        ST_WRITE: begin
          r_bank_wdata <= r_shift[BANK_WIDTH-1:0];
          r_bank_wr    <= 1'b1;
          r_state      <= ST_NEXT;
        end
        ST_NEXT: begin
          if (r_len == 8'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_len      <= r_len - 8'd1;
            r_byte_cnt <= '0;
            r_chk      <= '0;
            if (r_cmd_ai) begin
              r_addr <= r_addr + c_AW'(1);
            end
            r_state <= r_cmd_wr ? ST_WAIT_RX : ST_LOAD;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_bank_access_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_bank_access_engine
//  Purpose  : Scoreboard bench for pc_bank_access_engine (8 banks x 16 bits,
//             4-bit timeout). Follows PC_BANK_ACCESS_CHKSUM_EN like the RTL.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_bank_access_engine;

`ifdef PC_BANK_ACCESS_CHKSUM_EN
  localparam bit c_CHK = 1'b1;
`else
  localparam bit c_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_valid;
  logic [7:0]  pc_data_in;
  logic        pc_rd;
  logic        pc_rdy;
  logic [7:0]  pc_data_out;
  logic        pc_wr;
  logic [2:0]  bank_addr;
  logic [15:0] bank_rdata;
  logic [15:0] bank_wdata;
  logic        bank_wr;
  logic        busy;
  logic        err;

  logic [15:0] bank_mem [8];
  logic [7:0]  rx_q [$];
  logic [7:0]  exp_tx [$];
  logic [31:0] exp_wr [$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_pop = 0;
  int first_tx = -1;
  int tx_cnt = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;

  pc_bank_access_engine #(
    .NUM_BANKS     (8),
    .BANK_WIDTH    (16),
    .TIMEOUT_WIDTH (4)
  ) dut (
    .i_clk        (clk),
    .i_arst_n     (rst_n),
    .i_pc_valid   (pc_valid),
    .i_pc_data    (pc_data_in),
    .o_pc_rd      (pc_rd),
    .i_pc_rdy     (pc_rdy),
    .o_pc_data    (pc_data_out),
    .o_pc_wr      (pc_wr),
    .o_bank_addr  (bank_addr),
    .i_bank_rdata (bank_rdata),
    .o_bank_wdata (bank_wdata),
    .o_bank_wr    (bank_wr),
    .o_busy       (busy),
    .o_err        (err)
  );

  assign bank_rdata = bank_mem[bank_addr];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  task automatic push_rx_bank(input logic [15:0] v);
    rx_q.push_back(v[15:8]);
    rx_q.push_back(v[7:0]);
    if (c_CHK) rx_q.push_back(v[15:8] ^ v[7:0]);
  endtask

  task automatic push_tx_bank(input logic [15:0] v);
    exp_tx.push_back(v[15:8]);
    exp_tx.push_back(v[7:0]);
    if (c_CHK) exp_tx.push_back(v[15:8] ^ v[7:0]);
  endtask

  task automatic wait_done(input int budget, input string tag);
    logic done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (rx_q.size() == 0) && (exp_tx.size() == 0) &&
             (exp_wr.size() == 0) && !busy;
    end
    check_val(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_err(input int e0, input int budget, input string tag);
    for (int i = 0; i < budget && err_cnt == e0; i++) @(negedge clk);
    check_val(tag, 32'(err_cnt - e0), 32'd1);
  endtask

  // UART RX source: presents the queue head, pops on o_pc_rd.
  initial begin
    logic pop;
    pc_valid   = 1'b0;
    pc_data_in = 8'h00;
    forever begin
      @(negedge clk);
      pop = pc_rd;
      @(posedge clk);
      #1;
      if (pop && rx_q.size() > 0) begin
        void'(rx_q.pop_front());
        last_pop = cyc;
      end
      pc_valid   = (rx_q.size() != 0);
      pc_data_in = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end
  end

  // TX sink scoreboard.
  initial forever begin
    @(negedge clk);
    if (pc_wr) begin
      tx_cnt++;
      if (first_tx < 0) first_tx = cyc;
      if (exp_tx.size() == 0) check_val("tx_unexpected", 32'(pc_wr), 32'd0);
      else check_val("tx_byte", 32'(pc_data_out), 32'(exp_tx.pop_front()));
    end
  end

  // Bank write scoreboard.
  initial forever begin
    @(negedge clk);
    if (bank_wr) begin
      wr_cnt++;
      if (exp_wr.size() == 0) check_val("wr_unexpected", 32'(bank_wr), 32'd0);
      else check_val("wr_addr_data", {13'd0, bank_addr, bank_wdata}, exp_wr.pop_front());
    end
  end

  // Error pulse counter.
  initial forever begin
    @(negedge clk);
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int w0;
    int t0;
    int ok;
    rst_n  = 1'b0;
    pc_rdy = 1'b1;
    for (int i = 0; i < 8; i++) bank_mem[i] = 16'h1111 * 16'(i);
    bank_mem[1] = 16'h0F0E;
    bank_mem[2] = 16'h1234;
    bank_mem[3] = 16'hABCD;
    bank_mem[6] = 16'hC3A5;
    bank_mem[7] = 16'h7E81;

    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_pc_wr", 32'(pc_wr), 32'd0);
    check_val("rst_bank_wr", 32'(bank_wr), 32'd0);
    check_val("rst_bank_addr", 32'(bank_addr), 32'd0);
    check_val("rst_pc_data", 32'(pc_data_out), 32'd0);
    check_val("rst_bank_wdata", 32'(bank_wdata), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two-bank auto-increment read.
    e0 = err_cnt; first_tx = -1;
    push_tx_bank(16'h1234);
    push_tx_bank(16'hABCD);
    push_rx(8'h42); push_rx(8'h01);
    wait_done(200, "read_done");
    check_val("read_no_err", 32'(err_cnt - e0), 32'd0);
    ok = ((first_tx - (last_pop - 1)) >= 3) ? 1 : 0;
    check_val("read_latency_ge3", 32'(ok), 32'd1);

    // Single-bank write.
    w0 = wr_cnt;
    exp_wr.push_back({13'd0, 3'd5, 16'hBEEF});
    push_rx(8'hC5); push_rx(8'h00); push_rx_bank(16'hBEEF);
    wait_done(200, "write_done");
    check_val("write_count", 32'(wr_cnt - w0), 32'd1);

    // Range error with auto-increment running past the last bank.
    e0 = err_cnt; t0 = tx_cnt;
    push_rx(8'h47); push_rx(8'h03);
    wait_err(e0, 50, "range_err");
    @(negedge clk);
    check_val("range_busy_low", 32'(busy), 32'd0);
    check_val("range_no_tx", 32'(tx_cnt - t0), 32'd0);

    // Start address beyond the bank count.
    e0 = err_cnt;
    push_rx(8'h09); push_rx(8'h00);
    wait_err(e0, 50, "start_range_err");
    wait_done(50, "start_range_idle");

    // Auto-increment ending exactly on the last bank is legal.
    e0 = err_cnt;
    push_tx_bank(16'hC3A5);
    push_tx_bank(16'h7E81);
    push_rx(8'h46); push_rx(8'h01);
    wait_done(200, "edge_read_done");
    check_val("edge_read_no_err", 32'(err_cnt - e0), 32'd0);

    // Fixed address, LEN=2: same bank three times.
    push_tx_bank(16'h7E81);
    push_tx_bank(16'h7E81);
    push_tx_bank(16'h7E81);
    push_rx(8'h07); push_rx(8'h02);
    wait_done(300, "poll_read_done");

    // Inter-byte timeout on a partial bank.
    e0 = err_cnt; w0 = wr_cnt;
    push_rx(8'h81); push_rx(8'h00); push_rx(8'h11);
    wait_err(e0, 80, "timeout_err");
    ok = ((err_cyc - last_pop) >= 15 && (err_cyc - last_pop) <= 20) ? 1 : 0;
    check_val("timeout_window", 32'(ok), 32'd1);
    check_val("timeout_no_write", 32'(wr_cnt - w0), 32'd0);
    wait_done(50, "timeout_idle");

    // Timeout in the second bank keeps the first bank's write.
    e0 = err_cnt; w0 = wr_cnt;
    exp_wr.push_back({13'd0, 3'd2, 16'hBEEF});
    push_rx(8'hC2); push_rx(8'h01); push_rx_bank(16'hBEEF); push_rx(8'h11);
    wait_err(e0, 100, "timeout2_err");
    check_val("timeout2_one_write", 32'(wr_cnt - w0), 32'd1);
    wait_done(50, "timeout2_idle");

    // Backpressure: TX held off for 50 cycles.
    @(posedge clk); #1 pc_rdy = 1'b0;
    e0 = err_cnt; t0 = tx_cnt;
    push_tx_bank(16'h0F0E);
    push_rx(8'h41); push_rx(8'h00);
    repeat (50) @(negedge clk);
    check_val("bp_no_tx", 32'(tx_cnt - t0), 32'd0);
    check_val("bp_no_err", 32'(err_cnt - e0), 32'd0);
    check_val("bp_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 pc_rdy = 1'b1;
    wait_done(100, "bp_done");
    check_val("bp_tx_count", 32'(tx_cnt - t0), 32'(c_CHK ? 3 : 2));

`ifdef PC_BANK_ACCESS_CHKSUM_EN
    // Checksum accepted, then rejected.
    w0 = wr_cnt; e0 = err_cnt;
    exp_wr.push_back({13'd0, 3'd1, 16'h1234});
    push_rx(8'h81); push_rx(8'h00); push_rx(8'h12); push_rx(8'h34); push_rx(8'h26);
    wait_done(200, "chk_good_done");
    check_val("chk_good_write", 32'(wr_cnt - w0), 32'd1);
    w0 = wr_cnt;
    push_rx(8'h81); push_rx(8'h00); push_rx(8'h12); push_rx(8'h34); push_rx(8'h27);
    wait_err(e0, 80, "chk_bad_err");
    check_val("chk_bad_no_write", 32'(wr_cnt - w0), 32'd0);
    wait_done(50, "chk_bad_idle");
`endif

    // Reset in the middle of a frame aborts silently.
    e0 = err_cnt;
    push_rx(8'h42);
    for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    rx_q.delete();
    repeat (2) @(negedge clk);
    check_val("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val("midrst_no_err", 32'(err_cnt - e0), 32'd0);
    w0 = wr_cnt;
    exp_wr.push_back({13'd0, 3'd3, 16'h55AA});
    push_rx(8'hC3); push_rx(8'h00); push_rx_bank(16'h55AA);
    wait_done(200, "midrst_write_done");
    check_val("midrst_write_count", 32'(wr_cnt - w0), 32'd1);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
